// File: rtl/fht_unload_pkg.sv
// Shared definitions for the FHT result reader.
//   state_t  : unload FSM states
//   N_BANK   : number of data banks feeding the reader
//   bit_rev  : reverse the low w bits of v (upper result bits are zero)
package fht_unload_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int N_BANK = 4;

  function automatic logic [31:0] bit_rev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (i < w) r[i] = v[5'(w - 1 - i)];
    return r;
  endfunction

endpackage

// File: rtl/fht_unload_if.sv
// Output sample stream of the FHT result reader (valid/ready).
//   oDATA  : sample
//   oVALID : oDATA valid
//   oLAST  : final sample of the frame
//   iREADY : sink accepts; transfer when oVALID & iREADY
interface fht_unload_if #(
  parameter int D_BIT = 16
);
  logic [D_BIT-1:0] oDATA;
  logic             oVALID;
  logic             oLAST;
  logic             iREADY;

  modport master (output oDATA, oVALID, oLAST, input iREADY);
  modport slave  (input oDATA, oVALID, oLAST, output iREADY);
endinterface

// File: rtl/fht_unload_fifo.sv
// Small synchronous skid FIFO holding returned bank data until the sink
// takes it. Depth need not be a power of two.
//   clk/rst : clock, synchronous active-high reset (clears storage too)
//   push/din: write side
//   pop     : read side; dout is the head, stable until popped
//   empty   : no entries
//   count   : number of entries held
module fht_unload_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic                    full, pop_ok;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign pop_ok = pop & ~empty;
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Push into a full FIFO is only legal together with a pop; the write
      // then lands on the slot being vacated by the head.
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop_ok) rd_ptr <= nxt(rd_ptr);
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop_ok));

endmodule

// File: rtl/fht_unload.sv
// Result reader for the FHT core: after the transform completes it reads
// the four data banks and streams all 4*2^A_BIT points, in natural or
// bit-reversed order, on a valid/ready interface. Bank read latency is
// absorbed by a credit-controlled skid FIFO so backpressure never drops or
// duplicates a sample.
//   iCLK, iRESET       : clock, synchronous active-high reset
//   iSTART, iBIT_REV   : unload request (IDLE only) and order select
//   oRD_EN, oADDR_RD,
//   oBANK_SEL          : bank read request (address shared by all banks)
//   iDATA_0..iDATA_3   : bank read data, valid RD_LAT cycles after oRD_EN
//   str                : output sample stream (oDATA/oVALID/oLAST/iREADY)
//   oBUSY, oDONE       : busy level, one-cycle completion pulse
module fht_unload
  import fht_unload_pkg::*;
#(
  parameter int A_BIT      = 8,
  parameter int D_BIT      = 16,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = RD_LAT + 2
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic               iSTART,
  input  logic               iBIT_REV,
  output logic               oRD_EN,
  output logic [A_BIT-1:0]   oADDR_RD,
  output logic [1:0]         oBANK_SEL,
  input  logic [D_BIT-1:0]   iDATA_0,
  input  logic [D_BIT-1:0]   iDATA_1,
  input  logic [D_BIT-1:0]   iDATA_2,
  input  logic [D_BIT-1:0]   iDATA_3,
  fht_unload_if.master       str,
  output logic               oBUSY,
  output logic               oDONE
);

  localparam int              KW     = A_BIT + 2;
  localparam logic [KW-1:0]   K_LAST = '1;
  localparam int              CW     = $clog2(FIFO_DEPTH + 1);

  state_t                   state;
  logic [KW-1:0]            k, push_cnt, p;
  logic                     rev_q;

  // Read-return pipe: stage 0 is the issued strobe itself, stage RD_LAT is
  // the cycle the bank data is valid.
  logic [RD_LAT-1:0]        vld_q;
  logic [RD_LAT-1:0][1:0]   bank_q;
  logic [RD_LAT:0]          vld_pipe;

  logic                     push, pop, empty, credit_ok;
  logic [D_BIT:0]           fifo_din, fifo_dout;
  logic [D_BIT-1:0]         rd_data;
  logic [CW-1:0]            fifo_cnt;
  logic [3:0]               inflight;
  logic [4:0]               used;

  assign vld_pipe = {vld_q, oRD_EN};
  assign push     = vld_q[RD_LAT-1];
  assign p        = rev_q ? KW'(bit_rev(32'(k), KW)) : k;

  always_comb begin
    rd_data = iDATA_0;
    unique case (bank_q[RD_LAT-1])
      2'd0: rd_data = iDATA_0;
      2'd1: rd_data = iDATA_1;
      2'd2: rd_data = iDATA_2;
      2'd3: rd_data = iDATA_3;
    endcase
  end

  // Last flag travels with the sample, set on the N-th push of the frame.
  assign fifo_din = {(push_cnt == K_LAST), rd_data};

  fht_unload_fifo #(
    .W     (D_BIT + 1),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (iCLK),
    .rst   (iRESET),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (empty),
    .count (fifo_cnt)
  );

  assign str.oVALID = ~empty;
  assign str.oDATA  = fifo_dout[D_BIT-1:0];
  assign str.oLAST  = fifo_dout[D_BIT] & ~empty;
  assign pop        = ~empty & str.iREADY;

  // Credits: every read in the pipe will land in the FIFO; a pop this cycle
  // frees a slot in time for a read issued now, which keeps full rate.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= RD_LAT; i++) inflight = inflight + {3'b0, vld_pipe[i]};
    used      = 5'(fifo_cnt) + 5'(inflight) - 5'(pop);
    credit_ok = (used < 5'(FIFO_DEPTH));
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state     <= IDLE;
      k         <= '0;
      rev_q     <= 1'b0;
      push_cnt  <= '0;
      vld_q     <= '0;
      bank_q    <= '0;
      oRD_EN    <= 1'b0;
      oADDR_RD  <= '0;
      oBANK_SEL <= '0;
      oBUSY     <= 1'b0;
      oDONE     <= 1'b0;
    end else begin
      oRD_EN    <= 1'b0;
      oDONE     <= 1'b0;
      vld_q[0]  <= oRD_EN;
      bank_q[0] <= oBANK_SEL;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        bank_q[i] <= bank_q[i-1];
      end
      if (push) push_cnt <= push_cnt + 1'b1;

      case (state)
        IDLE: if (iSTART) begin
          rev_q    <= iBIT_REV;
          k        <= '0;
          push_cnt <= '0;
          oBUSY    <= 1'b1;
          state    <= RUN;
        end
        RUN: if (credit_ok) begin
          oRD_EN    <= 1'b1;
          oADDR_RD  <= p[A_BIT-1:0];
          oBANK_SEL <= p[KW-1:A_BIT];
          if (k == K_LAST) state <= DRAIN;
          else             k     <= k + 1'b1;
        end
        // The last-tagged sample is the final read returned, so its
        // transfer implies nothing is left in the pipe or the FIFO.
        DRAIN: if (pop && str.oLAST) begin
          oDONE <= 1'b1;
          oBUSY <= 1'b0;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
